dir_entry_buffer: RTL and testbench
===================================

// Module: dir_entry_buffer
// PURPOSE
// - Sits between the SD/FAT sector reader and the ASCII OSD: consumes the raw byte stream of FAT
//   directory sectors and filters it into a list of displayable file entries.
// - Stores each accepted entry as one 16-character OSD row, plus its start cluster and size.
// - Serves characters to the OSD (dir_row/dir_col -> dir_chr) and reports the entry count (dir_len).
// - On file selection, returns the chosen file's start cluster and size to the reader.
// PARAMETERS
// - MAX_ENTRIES  32     entries stored; range 1..63; dir_len saturates here
// - FILTER_EN    1      1 = accept only files whose extension equals EXT_FILTER
// - EXT_FILTER   "ST "  3-byte extension compared against dir bytes 8..10, byte 8 in the MSB
// PORTS
// - clk            in   1   system clock
// - reset          in   1   synchronous, active-high
// - start          in   1   pulse: clear list, begin new directory scan
// - data           in   8   directory byte, in sector order
// - data_valid     in   1   data qualifier, at most one byte per clk
// - end_of_dir     in   1   pulse: reader has no more directory sectors
// - busy           out  1   scan in progress
// - dir_row        in   8   OSD row being fetched
// - dir_col        in   4   OSD column being fetched
// - dir_chr        out  8   character at (dir_row, dir_col), registered
// - dir_len        out  6   number of accepted entries
// - file_index     in   8   entry chosen in OSD
// - file_selected  in   1   pulse: latch metadata of file_index
// - file_cluster   out  16  start cluster of selected file
// - file_size      out  32  byte size of selected file
// - file_valid     out  1   1-cycle pulse: file_cluster/file_size updated
// BEHAVIOUR
// - Reset: state IDLE; busy=0, dir_len=0, dir_chr=0x20, file_cluster=0, file_size=0, file_valid=0.
// - FSM:
//   - IDLE --start--> SCAN; SCAN --end_of_dir--> DONE; SCAN --entry with byte0==0x00--> DONE.
//   - start in any state -> SCAN, clearing byte counter and dir_len (reset mid-scan restarts cleanly).
//   - start has priority over a same-cycle data_valid/end_of_dir; data_valid is ignored outside SCAN.
// - Byte counter bcnt[4:0] advances on each data_valid in SCAN and wraps 31->0 (one 32-byte entry).
// - Character writes go to row dir_len, only while dir_len<MAX_ENTRIES, one write per byte:
//   - bcnt 0..7 -> col 0..7 = data (byte0 0x05 is written as 0xE5);
//   - bcnt 8..10 -> col 9..11 = data; bcnt 11 -> col 8 = '.'; bcnt 12..15 -> col 12..15 = 0x20.
// - Accept flags latched during the entry; a skipped entry's writes are never committed:
//   - skip if byte0==0xE5 (deleted);
//   - skip if attr (byte 11)==0x0F (LFN);
//   - skip if attr&0x18 != 0 (volume label / directory);
//   - skip if FILTER_EN and bytes 8..10 != EXT_FILTER.
// - Metadata:
//   - cluster = {byte27, byte26}; size = {byte31, byte30, byte29, byte28} (little endian);
//   - written to meta[dir_len] at bcnt 31.
// - Commit: at bcnt 31, if accepted and dir_len<MAX_ENTRIES, dir_len increments next cycle.
//   When full, further entries are parsed but not stored.
// - A partial entry pending at end_of_dir is discarded; dir_len is unchanged.
// - Read port:
//   - dir_chr = RAM[dir_row][dir_col] one clk after dir_row/dir_col, readable in any state;
//   - rows >= MAX_ENTRIES return 0x20; rows >= dir_len return stale data (OSD masks them).
// - Selection:
//   - file_selected with file_index<dir_len: next clk, file_cluster/file_size = meta[file_index] and file_valid=1 for one clk;
//   - file_index>=dir_len: no update, file_valid stays 0.
// - busy = (state==SCAN).
// TESTING
// - Entries "GAME    ST " attr 0x20 clu 0x0123 size 737280, then byte0=0x00 -> dir_len=1,
//   row0 reads "GAME    .ST     ", busy falls, later bytes ignored.
// - Deleted (0xE5), LFN (attr 0x0F), dir (attr 0x10), "README  TXT" then valid "DEMO    ST "
//   -> dir_len=1, row0="DEMO    .ST     ".
// - 40 valid entries, MAX_ENTRIES=32 -> dir_len=32, row 31 holds entry 31, entries 32..39 not stored.
// - Select file_index=0 after test 1 -> next clk file_cluster=0x0123, file_size=737280, file_valid 1 clk;
//   file_index=5 -> file_valid stays 0.
// - start asserted at bcnt=17 of entry 3 -> dir_len=0, new scan from byte 0, old rows overwritten.
// - end_of_dir at bcnt=20 -> DONE, dir_len excludes partial entry; reset mid-scan -> all outputs at reset values.

Source files
------------

// File: rtl/dir_entry_if.sv
// dir_entry_if: scan, OSD read and file-select signals of the directory entry buffer
interface dir_entry_if;
    logic        start;
    logic [7:0]  data;
    logic        data_valid;
    logic        end_of_dir;
    logic        busy;
    logic [7:0]  dir_row;
    logic [3:0]  dir_col;
    logic [7:0]  dir_chr;
    logic [5:0]  dir_len;
    logic [7:0]  file_index;
    logic        file_selected;
    logic [15:0] file_cluster;
    logic [31:0] file_size;
    logic        file_valid;

    modport master (
        output start, data, data_valid, end_of_dir, dir_row, dir_col, file_index, file_selected,
        input  busy, dir_chr, dir_len, file_cluster, file_size, file_valid
    );
    modport slave (
        input  start, data, data_valid, end_of_dir, dir_row, dir_col, file_index, file_selected,
        output busy, dir_chr, dir_len, file_cluster, file_size, file_valid
    );
endinterface

// File: rtl/dir_entry_buffer.sv
// dir_entry_buffer: filters FAT directory bytes into 16-char OSD rows plus cluster/size metadata
module dir_entry_buffer #(
    parameter int          MAX_ENTRIES = 32,
    parameter bit          FILTER_EN   = 1'b1,
    parameter logic [23:0] EXT_FILTER  = "ST "
) (
    input logic       clk,
    input logic       reset,
    dir_entry_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
    localparam logic [5:0] MAX  = 6'(MAX_ENTRIES);
    localparam logic [7:0] ROWS = 8'(MAX_ENTRIES);

    logic [1:0]  state;
    logic [4:0]  bcnt;
    logic [5:0]  dir_len;
    logic        skip;
    logic [15:0] clu;
    logic [23:0] size_lo;
    logic [7:0]  ram [64][16];
    logic [15:0] meta_clu [64];
    logic [31:0] meta_size [64];
    logic        take, room, skip_now, wr_en;
    logic [7:0]  ext_byte, wr_chr;
    logic [3:0]  wr_col;

    always_comb begin
        take     = state == SCAN && bus.data_valid && !bus.start;
        room     = dir_len < MAX;
        ext_byte = bcnt == 5'd8 ? EXT_FILTER[23:16] : bcnt == 5'd9 ? EXT_FILTER[15:8] : EXT_FILTER[7:0];
        skip_now = (bcnt == 5'd0 && bus.data == 8'hE5)
                || (FILTER_EN && bcnt >= 5'd8 && bcnt <= 5'd10 && bus.data != ext_byte)
                || (bcnt == 5'd11 && (bus.data == 8'h0F || bus.data[4:3] != 2'b00));
        // Rows past dir_len are scratch, so every entry writes straight into the next free row
        wr_en    = take && room && !bcnt[4];
        wr_col   = bcnt == 5'd11 ? 4'd8 : (bcnt >= 5'd8 && bcnt <= 5'd10) ? bcnt[3:0] + 4'd1 : bcnt[3:0];
        wr_chr   = bcnt == 5'd11 ? 8'h2E : bcnt >= 5'd12 ? 8'h20
                 : (bcnt == 5'd0 && bus.data == 8'h05) ? 8'hE5 : bus.data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bcnt    <= '0;
            dir_len <= '0;
            skip    <= 1'b0;
            clu     <= '0;
            size_lo <= '0;
        end else if (bus.start) begin
            state   <= SCAN;
            bcnt    <= '0;
            dir_len <= '0;
        end else if (state == SCAN) begin
            if (bus.end_of_dir)
                state <= DONE;
            else if (bus.data_valid) begin
                bcnt <= bcnt + 5'd1;
                skip <= bcnt == 5'd0 ? skip_now : skip | skip_now;
                if (bcnt == 5'd0 && bus.data == 8'h00) state <= DONE;
                if (bcnt == 5'd26) clu[7:0] <= bus.data;
                if (bcnt == 5'd27) clu[15:8] <= bus.data;
                if (bcnt == 5'd28) size_lo[7:0] <= bus.data;
                if (bcnt == 5'd29) size_lo[15:8] <= bus.data;
                if (bcnt == 5'd30) size_lo[23:16] <= bus.data;
                if (bcnt == 5'd31 && !skip && room) dir_len <= dir_len + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram[dir_len][wr_col] <= wr_chr;
        if (take && bcnt == 5'd31 && room) begin
            meta_clu[dir_len]  <= clu;
            meta_size[dir_len] <= {bus.data, size_lo};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dir_chr      <= 8'h20;
            bus.file_cluster <= '0;
            bus.file_size    <= '0;
            bus.file_valid   <= 1'b0;
        end else begin
            bus.dir_chr    <= bus.dir_row < ROWS ? ram[bus.dir_row[5:0]][bus.dir_col] : 8'h20;
            bus.file_valid <= bus.file_selected && bus.file_index < {2'b00, dir_len};
            if (bus.file_selected && bus.file_index < {2'b00, dir_len}) begin
                bus.file_cluster <= meta_clu[bus.file_index[5:0]];
                bus.file_size    <= meta_size[bus.file_index[5:0]];
            end
        end
    end

    assign bus.busy    = state == SCAN;
    assign bus.dir_len = dir_len;
endmodule

// File: tb/tb_dir_entry_buffer.sv
// tb_dir_entry_buffer: table vectors, directed corner sequences and randomized scans vs an entry-level model
module tb_dir_entry_buffer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dir_entry_if bus();
    dir_entry_buffer #(.MAX_ENTRIES(32), .FILTER_EN(1'b1), .EXT_FILTER("ST ")) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [63:0] name;
        logic [23:0] ext;
        logic [7:0]  attr;
        logic [15:0] clu;
        logic [31:0] size;
    } ent_t;
    typedef struct {
        ent_t e;
        int   exp_len;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] eb(input ent_t e, input int i);
        if (i < 8) return e.name[8*(7-i) +: 8];
        if (i < 11) return e.ext[8*(10-i) +: 8];
        if (i == 11) return e.attr;
        if (i < 26) return 8'(8'hA5 ^ i);
        if (i == 26) return e.clu[7:0];
        if (i == 27) return e.clu[15:8];
        return e.size[8*(i-28) +: 8];
    endfunction

    function automatic bit acc(input ent_t e);
        return e.name[63:56] != 8'hE5 && e.name[63:56] != 8'h00 && e.attr != 8'h0F
            && (e.attr & 8'h18) == 8'h00 && e.ext == "ST ";
    endfunction

    function automatic logic [127:0] exp_row(input ent_t e);
        logic [7:0] c0;
        c0 = e.name[63:56] == 8'h05 ? 8'hE5 : e.name[63:56];
        return {c0, e.name[55:0], 8'h2E, e.ext, 32'h20202020};
    endfunction

    function automatic ent_t mk(input logic [63:0] n, input logic [23:0] x, input logic [7:0] a,
                                input logic [15:0] c, input logic [31:0] s);
        ent_t e;
        e.name = n; e.ext = x; e.attr = a; e.clu = c; e.size = s;
        return e;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.data = b;
        bus.data_valid = 1'b1;
    endtask

    task automatic send_entry(input ent_t e);
        for (int i = 0; i < 32; i++) send_byte(eb(e, i));
    endtask

    task automatic stop_data();
        @(negedge clk);
        bus.data_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.data_valid = 1'b0;
    endtask

    task automatic pulse_eod();
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.end_of_dir = 1'b1;
        @(negedge clk);
        bus.end_of_dir = 1'b0;
    endtask

    task automatic read_row(input logic [7:0] row, output logic [127:0] r);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus.dir_row = row;
            bus.dir_col = 4'(c);
            @(negedge clk);
            r[127-8*c -: 8] = bus.dir_chr;
        end
    endtask

    task automatic select(input logic [7:0] idx, output logic v1, output logic [15:0] c,
                          output logic [31:0] s, output logic v2);
        @(negedge clk);
        bus.file_index = idx;
        bus.file_selected = 1'b1;
        @(negedge clk);
        bus.file_selected = 1'b0;
        v1 = bus.file_valid;
        c = bus.file_cluster;
        s = bus.file_size;
        @(negedge clk);
        v2 = bus.file_valid;
    endtask

    vec_t vecs[10];
    ent_t stored[$];
    ent_t e, game, demo;
    logic [127:0] row;
    logic v1, v2;
    logic [15:0] c;
    logic [31:0] s;
    logic [63:0] nm;
    logic [7:0] attrs[7] = '{8'h20, 8'h00, 8'h01, 8'h0F, 8'h10, 8'h08, 8'h22};
    bit done;
    int n, k;

    initial begin
        vecs[0] = '{mk("GAME    ", "ST ", 8'h20, 16'h0123, 32'd737280), 1};
        vecs[1] = '{mk({8'hE5, "AME    "}, "ST ", 8'h20, 16'h0011, 32'd10), 0};
        vecs[2] = '{mk("LFNENTRY", "ST ", 8'h0F, 16'h0022, 32'd20), 0};
        vecs[3] = '{mk("SUBDIR  ", "ST ", 8'h10, 16'h0033, 32'd30), 0};
        vecs[4] = '{mk("VOLUME  ", "ST ", 8'h08, 16'h0044, 32'd40), 0};
        vecs[5] = '{mk("README  ", "TXT", 8'h20, 16'h0055, 32'd50), 0};
        vecs[6] = '{mk("DEMO    ", "ST ", 8'h00, 16'hBEEF, 32'h12345678), 1};
        vecs[7] = '{mk({8'h05, "ANJI   "}, "ST ", 8'h21, 16'h0777, 32'd99), 1};
        vecs[8] = '{mk("HIDDEN  ", "ST ", 8'h02, 16'hFFFF, 32'hFFFFFFFF), 1};
        vecs[9] = '{mk("ALMOST  ", "STX", 8'h20, 16'h0099, 32'd90), 0};
        game = vecs[0].e;
        demo = vecs[6].e;

        reset = 1'b1;
        bus.start = 0; bus.data = 0; bus.data_valid = 0; bus.end_of_dir = 0;
        bus.dir_row = 8'd40; bus.dir_col = 0; bus.file_index = 0; bus.file_selected = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_len", 128'(bus.dir_len), 128'(0));
        chk("rst_chr", 128'(bus.dir_chr), 128'(8'h20));
        chk("rst_clu", 128'(bus.file_cluster), 128'(0));
        chk("rst_size", 128'(bus.file_size), 128'(0));
        chk("rst_valid", 128'(bus.file_valid), 128'(0));
        reset = 1'b0;

        // table: one entry per scan
        for (int i = 0; i < 10; i++) begin
            pulse_start();
            send_entry(vecs[i].e);
            stop_data();
            pulse_eod();
            chk($sformatf("vec%0d_len", i), 128'(bus.dir_len), 128'(vecs[i].exp_len));
            chk($sformatf("vec%0d_busy", i), 128'(bus.busy), 128'(0));
            if (vecs[i].exp_len == 1) begin
                read_row(8'd0, row);
                chk($sformatf("vec%0d_row", i), row, exp_row(vecs[i].e));
                select(8'd0, v1, c, s, v2);
                chk($sformatf("vec%0d_meta", i), {v1, c, s}, {1'b1, vecs[i].e.clu, vecs[i].e.size});
            end
        end

        // end marker entry stops the scan
        pulse_start();
        chk("t1_busy_on", 128'(bus.busy), 128'(1));
        send_entry(game);
        send_byte(8'h00);
        stop_data();
        chk("t1_busy_off", 128'(bus.busy), 128'(0));
        chk("t1_len", 128'(bus.dir_len), 128'(1));
        send_entry(demo);
        stop_data();
        chk("t1_len_after", 128'(bus.dir_len), 128'(1));
        read_row(8'd0, row);
        chk("t1_row0", row, "GAME    .ST     ");
        select(8'd0, v1, c, s, v2);
        chk("t1_sel_valid", 128'(v1), 128'(1));
        chk("t1_sel_meta", {c, s}, {16'h0123, 32'd737280});
        chk("t1_sel_pulse", 128'(v2), 128'(0));
        select(8'd5, v1, c, s, v2);
        chk("t1_bad_sel", {v1, v2, c, s}, {2'b00, 16'h0123, 32'd737280});

        // rejects followed by one keeper
        pulse_start();
        for (int i = 1; i <= 5; i++) send_entry(vecs[i].e);
        send_entry(demo);
        stop_data();
        pulse_eod();
        chk("t2_len", 128'(bus.dir_len), 128'(1));
        read_row(8'd0, row);
        chk("t2_row0", row, "DEMO    .ST     ");

        // overflow past MAX_ENTRIES
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            e = mk({"F", 8'(48 + i / 10), 8'(48 + i % 10), "     "}, "ST ", 8'h20, 16'(i * 3), 32'(i * 1000));
            send_entry(e);
        end
        stop_data();
        pulse_eod();
        chk("t3_len", 128'(bus.dir_len), 128'(32));
        read_row(8'd31, row);
        chk("t3_row31", row, "F31     .ST     ");
        read_row(8'd32, row);
        chk("t3_row32", row, {16{8'h20}});
        select(8'd31, v1, c, s, v2);
        chk("t3_sel31", {v1, c, s}, {1'b1, 16'd93, 32'd31000});
        select(8'd32, v1, c, s, v2);
        chk("t3_sel32", 128'(v1), 128'(0));

        // restart mid-entry, start beats the same-cycle byte
        pulse_start();
        for (int i = 0; i < 3; i++) send_entry(demo);
        for (int i = 0; i < 17; i++) send_byte(eb(game, i));
        pulse_start();
        chk("t5_len", 128'(bus.dir_len), 128'(0));
        chk("t5_busy", 128'(bus.busy), 128'(1));
        send_entry(mk("NEW     ", "ST ", 8'h20, 16'h4242, 32'd7));
        stop_data();
        chk("t5_len1", 128'(bus.dir_len), 128'(1));
        read_row(8'd0, row);
        chk("t5_row0", row, "NEW     .ST     ");

        // partial entry at end_of_dir
        pulse_start();
        send_entry(game);
        for (int i = 0; i < 20; i++) send_byte(eb(demo, i));
        pulse_eod();
        chk("t6_busy", 128'(bus.busy), 128'(0));
        chk("t6_len", 128'(bus.dir_len), 128'(1));
        send_entry(demo);
        stop_data();
        chk("t6_ignored", 128'(bus.dir_len), 128'(1));

        // reset mid-scan
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(eb(demo, i));
        bus.dir_row = 8'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t7_outs", {bus.busy, bus.dir_len, bus.dir_chr, bus.file_cluster, bus.file_size, bus.file_valid},
            {1'b0, 6'd0, 8'h20, 16'd0, 32'd0, 1'b0});
        reset = 1'b0;
        send_entry(demo);
        stop_data();
        chk("t7_idle", {bus.busy, bus.dir_len}, {1'b0, 6'd0});

        // randomized scans against the entry-level model
        for (int r = 0; r < 3; r++) begin
            stored.delete();
            done = 0;
            pulse_start();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 19);
                nm[63:56] = k == 0 ? 8'hE5 : k == 1 ? 8'h05 : (k == 2 && r == 2) ? 8'h00 : 8'(65 + $urandom_range(0, 25));
                for (int j = 1; j < 8; j++) nm[63-8*j -: 8] = 8'(65 + $urandom_range(0, 25));
                e = mk(nm, $urandom_range(0, 3) == 0 ? "TXT" : "ST ", attrs[$urandom_range(0, 6)],
                       16'($urandom), 32'($urandom));
                send_entry(e);
                if (!done) begin
                    if (e.name[63:56] == 8'h00) done = 1;
                    else if (acc(e) && stored.size() < 32) stored.push_back(e);
                end
            end
            stop_data();
            pulse_eod();
            chk($sformatf("rnd%0d_len", r), 128'(bus.dir_len), 128'(stored.size()));
            foreach (stored[q]) begin
                read_row(8'(q), row);
                chk($sformatf("rnd%0d_row%0d", r, q), row, exp_row(stored[q]));
            end
            if (stored.size() > 0) begin
                k = $urandom_range(0, stored.size() - 1);
                select(8'(k), v1, c, s, v2);
                chk($sformatf("rnd%0d_sel%0d", r, k), {v1, c, s, v2}, {1'b1, stored[k].clu, stored[k].size, 1'b0});
            end
            select(8'(stored.size()), v1, c, s, v2);
            chk($sformatf("rnd%0d_selout", r), 128'(v1), 128'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
